pc_redirect_sched: RTL and testbench

Owns the fetch PC register and sequences every next-PC decision for the PRE_IF stage. It accepts redirect requests from writeback/MEM and EXE, and predictions from the BPU. It arbitrates them by fixed priority and applies the winner only when fetch can accept a new PC. A redirect that arrives while fetch is stalled is buffered until it can be applied, so no redirect is ever lost.

---
 rtl/pc_redirect_sched_pkg.sv | 39 +++
 rtl/pc_redirect_sched_prio_enc.sv | 30 +++
 rtl/pc_redirect_sched.sv | 104 ++++++++++
 tb/tb_pc_redirect_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_sched_pkg.sv
// Shared CPU definitions for next-PC selection: PC source encodings,
// redirect priorities and the redirect record passed between the encoder and scheduler.
package pc_redirect_sched_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        PCSEL_PC4     = 3'd0,
        PCSEL_TARGET  = 3'd1,
        PCSEL_CORRECT = 3'd2,
        PCSEL_EPC     = 3'd3,
        PCSEL_MEMPC   = 3'd4,
        PCSEL_EXCEPT  = 3'd5,
        PCSEL_HOLD    = 3'd7
    } pc_sel_e;

    // Numeric order matters: a larger value beats a smaller one.
    typedef enum logic [2:0] {
        PRIO_NONE    = 3'd0,
        PRIO_CORRECT = 3'd1,
        PRIO_MEMPC   = 3'd2,
        PRIO_EPC     = 3'd3,
        PRIO_EXCEPT  = 3'd4
    } redirect_prio_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } sched_state_e;

    typedef struct packed {
        redirect_prio_e    prio;
        pc_sel_e           sel;
        logic [ADDR_W-1:0] target;
    } redirect_t;

    localparam redirect_t REDIRECT_NONE = '{prio: PRIO_NONE, sel: PCSEL_PC4, target: '0};

endpackage

// File: rtl/pc_redirect_sched_prio_enc.sv
// Fixed-priority encoder: collapses the four redirect request ports into the
// single highest-priority redirect seen this cycle.
module redirect_prio_enc
    import pc_redirect_sched_pkg::*;
(
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    input  logic              eret_valid,
    input  logic [ADDR_W-1:0] eret_target,
    input  logic              refetch_valid,
    input  logic [ADDR_W-1:0] refetch_target,
    input  logic              mispred_valid,
    input  logic [ADDR_W-1:0] mispred_target,
    output redirect_t         req
);

    always_comb begin
        req = REDIRECT_NONE;
        if (exc_valid) begin
            req = '{prio: PRIO_EXCEPT, sel: PCSEL_EXCEPT, target: exc_target};
        end else if (eret_valid) begin
            req = '{prio: PRIO_EPC, sel: PCSEL_EPC, target: eret_target};
        end else if (refetch_valid) begin
            req = '{prio: PRIO_MEMPC, sel: PCSEL_MEMPC, target: refetch_target};
        end else if (mispred_valid) begin
            req = '{prio: PRIO_CORRECT, sel: PCSEL_CORRECT, target: mispred_target};
        end
    end

endmodule

// File: rtl/pc_redirect_sched.sv
// Fetch PC register and next-PC scheduler for PRE_IF: applies redirects, BPU
// predictions or sequential PCs, buffering a redirect while fetch is stalled.
module pc_redirect_sched
    import pc_redirect_sched_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_target,
    input  logic            eret_valid,
    input  logic [PC_W-1:0] eret_target,
    input  logic            refetch_valid,
    input  logic [PC_W-1:0] refetch_target,
    input  logic            mispred_valid,
    input  logic [PC_W-1:0] mispred_target,
    input  logic            bpu_valid,
    input  logic [PC_W-1:0] bpu_target,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      pc_sel,
    output logic            redirect_flush,
    output logic            redirect_pending
);

    sched_state_e    state, state_next;
    redirect_t       new_req, pend_req, pend_next, cand;
    logic            cand_valid;
    logic [PC_W-1:0] pc_next;
    logic            flush_next;
    pc_sel_e         sel_c;

    redirect_prio_enc u_prio_enc (
        .exc_valid      (exc_valid),
        .exc_target     (exc_target),
        .eret_valid     (eret_valid),
        .eret_target    (eret_target),
        .refetch_valid  (refetch_valid),
        .refetch_target (refetch_target),
        .mispred_valid  (mispred_valid),
        .mispred_target (mispred_target),
        .req            (new_req)
    );

    // A new request replaces the buffered one when at least as urgent; ties go
    // to the new one because the younger pipeline event is authoritative.
    always_comb begin
        cand = new_req;
        if (state == ST_HOLD &&
            (new_req.prio == PRIO_NONE || new_req.prio < pend_req.prio)) begin
            cand = pend_req;
        end
    end

    assign cand_valid = (cand.prio != PRIO_NONE);

    always_comb begin
        state_next = state;
        pend_next  = pend_req;
        pc_next    = pc;
        flush_next = 1'b0;
        sel_c      = PCSEL_PC4;
        if (fetch_ready) begin
            if (cand_valid) begin
                pc_next    = cand.target;
                sel_c      = cand.sel;
                flush_next = 1'b1;
                state_next = ST_IDLE;
                pend_next  = REDIRECT_NONE;
            end else if (bpu_valid) begin
                pc_next = bpu_target;
                sel_c   = PCSEL_TARGET;
            end else begin
                pc_next = pc + PC_W'(4);
            end
        end else if (cand_valid) begin
            // BPU predictions are not buffered; pc stays put so the BPU re-predicts.
            pend_next  = cand;
            state_next = ST_HOLD;
            sel_c      = PCSEL_HOLD;
        end
    end

    assign pc_sel = sel_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            pend_req         <= REDIRECT_NONE;
            pc               <= RESET_PC;
            redirect_flush   <= 1'b0;
            redirect_pending <= 1'b0;
        end else begin
            state            <= state_next;
            pend_req         <= pend_next;
            pc               <= pc_next;
            redirect_flush   <= flush_next;
            redirect_pending <= (state_next == ST_HOLD);
        end
    end

endmodule

// File: tb/tb_pc_redirect_sched.sv
// Self-checking bench for pc_redirect_sched: directed scenarios plus randomized
// traffic compared against a request-list reference model.
module tb_pc_redirect_sched;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic        fetch_ready;
    logic        exc_valid, eret_valid, refetch_valid, mispred_valid, bpu_valid;
    logic [31:0] exc_target, eret_target, refetch_target, mispred_target, bpu_target;
    logic [31:0] pc;
    logic [2:0]  pc_sel;
    logic        redirect_flush;
    logic        redirect_pending;

    int checks;
    int failures;

    logic [31:0] m_pc;
    bit          m_pend;
    int          m_pend_prio;
    int          m_pend_code;
    logic [31:0] m_pend_tgt;
    bit          m_flush;
    int          exp_sel;
    logic [2:0]  obs_sel;

    pc_redirect_sched #(.PC_W(32), .RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_ready      (fetch_ready),
        .exc_valid        (exc_valid),
        .exc_target       (exc_target),
        .eret_valid       (eret_valid),
        .eret_target      (eret_target),
        .refetch_valid    (refetch_valid),
        .refetch_target   (refetch_target),
        .mispred_valid    (mispred_valid),
        .mispred_target   (mispred_target),
        .bpu_valid        (bpu_valid),
        .bpu_target       (bpu_target),
        .pc               (pc),
        .pc_sel           (pc_sel),
        .redirect_flush   (redirect_flush),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_requests();
        exc_valid = 0; eret_valid = 0; refetch_valid = 0; mispred_valid = 0; bpu_valid = 0;
    endtask

    // Runs one clock: samples pc_sel mid-cycle, advances the reference model at
    // the edge, and returns #1 after the edge with registered outputs settled.
    task automatic applyStimulus();
        bit          req_v[4];
        int          req_prio[4];
        int          req_code[4];
        logic [31:0] req_tgt[4];
        int          best;
        bit          has_cand;
        int          c_prio, c_code;
        logic [31:0] c_tgt;
        @(negedge clk);
        req_v    = '{exc_valid, eret_valid, refetch_valid, mispred_valid};
        req_prio = '{4, 3, 2, 1};
        req_code = '{5, 3, 4, 2};
        req_tgt  = '{exc_target, eret_target, refetch_target, mispred_target};
        best = -1;
        for (int i = 0; i < 4; i++)
            if (req_v[i] && (best < 0 || req_prio[i] > req_prio[best])) best = i;
        has_cand = 0; c_prio = 0; c_code = 0; c_tgt = '0;
        if (best >= 0 && (!m_pend || req_prio[best] >= m_pend_prio)) begin
            has_cand = 1; c_prio = req_prio[best]; c_code = req_code[best]; c_tgt = req_tgt[best];
        end else if (m_pend) begin
            has_cand = 1; c_prio = m_pend_prio; c_code = m_pend_code; c_tgt = m_pend_tgt;
        end
        if (fetch_ready) exp_sel = has_cand ? c_code : (bpu_valid ? 1 : 0);
        else             exp_sel = has_cand ? 7 : 0;
        obs_sel = pc_sel;
        @(posedge clk);
        if (rst) begin
            m_pc = RESET_PC; m_pend = 0; m_flush = 0;
        end else if (fetch_ready) begin
            m_flush = has_cand;
            if (has_cand) begin
                m_pc = c_tgt; m_pend = 0;
            end else if (bpu_valid) begin
                m_pc = bpu_target;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            m_flush = 0;
            if (has_cand) begin
                m_pend = 1; m_pend_prio = c_prio; m_pend_code = c_code; m_pend_tgt = c_tgt;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; fetch_ready = 1; clear_requests();
        applyStimulus();
        applyStimulus();
        checks++; if (pc !== RESET_PC) begin failures++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
        checks++; if (redirect_flush !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush: got %b expected 0", redirect_flush); end
        checks++; if (redirect_pending !== 1'b0) begin failures++; $display("[TB] FAIL reset_pending: got %b expected 0", redirect_pending); end
        rst = 0;
        applyStimulus();
        checks++; if (pc !== 32'hBFC0_0004) begin failures++; $display("[TB] FAIL seq_pc1: got %h expected bfc00004", pc); end
        checks++; if (obs_sel !== 3'd0) begin failures++; $display("[TB] FAIL seq_sel: got %0d expected 0", obs_sel); end
        applyStimulus();
        checks++; if (pc !== 32'hBFC0_0008) begin failures++; $display("[TB] FAIL seq_pc2: got %h expected bfc00008", pc); end
        checks++; if (redirect_flush !== 1'b0) begin failures++; $display("[TB] FAIL seq_flush: got %b expected 0", redirect_flush); end
    endtask

    task automatic test_bpu();
        bpu_valid = 1; bpu_target = 32'hBFC0_0100; fetch_ready = 1;
        applyStimulus();
        checks++; if (pc !== 32'hBFC0_0100) begin failures++; $display("[TB] FAIL bpu_pc: got %h expected bfc00100", pc); end
        checks++; if (obs_sel !== 3'd1) begin failures++; $display("[TB] FAIL bpu_sel: got %0d expected 1", obs_sel); end
        bpu_target = 32'hBFC0_0200; fetch_ready = 0;
        applyStimulus();
        checks++; if (pc !== 32'hBFC0_0100) begin failures++; $display("[TB] FAIL bpu_stall_pc: got %h expected bfc00100", pc); end
        checks++; if (redirect_pending !== 1'b0) begin failures++; $display("[TB] FAIL bpu_stall_pending: got %b expected 0", redirect_pending); end
        checks++; if (obs_sel !== 3'd0) begin failures++; $display("[TB] FAIL bpu_stall_sel: got %0d expected 0", obs_sel); end
        clear_requests();
    endtask

    task automatic test_stall_buffer();
        logic [31:0] held;
        held = pc;
        fetch_ready = 0; mispred_valid = 1; mispred_target = 32'h8000_0040;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            mispred_valid = 0;
            checks++; if (redirect_pending !== 1'b1) begin failures++; $display("[TB] FAIL stall_pending[%0d]: got %b expected 1", i, redirect_pending); end
            checks++; if (pc !== held) begin failures++; $display("[TB] FAIL stall_pc[%0d]: got %h expected %h", i, pc, held); end
            checks++; if (obs_sel !== 3'd7) begin failures++; $display("[TB] FAIL stall_sel[%0d]: got %0d expected 7", i, obs_sel); end
        end
        fetch_ready = 1;
        applyStimulus();
        checks++; if (pc !== 32'h8000_0040) begin failures++; $display("[TB] FAIL release_pc: got %h expected 80000040", pc); end
        checks++; if (redirect_flush !== 1'b1) begin failures++; $display("[TB] FAIL release_flush: got %b expected 1", redirect_flush); end
        checks++; if (redirect_pending !== 1'b0) begin failures++; $display("[TB] FAIL release_pending: got %b expected 0", redirect_pending); end
        checks++; if (obs_sel !== 3'd2) begin failures++; $display("[TB] FAIL release_sel: got %0d expected 2", obs_sel); end
        applyStimulus();
        checks++; if (redirect_flush !== 1'b0) begin failures++; $display("[TB] FAIL flush_pulse: got %b expected 0", redirect_flush); end
        checks++; if (pc !== 32'h8000_0044) begin failures++; $display("[TB] FAIL after_release_pc: got %h expected 80000044", pc); end
    endtask

    task automatic test_priority_hold();
        fetch_ready = 0; mispred_valid = 1; mispred_target = 32'h1111_0000;
        applyStimulus();
        mispred_valid = 0; exc_valid = 1; exc_target = 32'hBFC0_0380;
        applyStimulus();
        exc_valid = 0; fetch_ready = 1;
        applyStimulus();
        checks++; if (pc !== 32'hBFC0_0380) begin failures++; $display("[TB] FAIL exc_over_correct_pc: got %h expected bfc00380", pc); end
        checks++; if (obs_sel !== 3'd5) begin failures++; $display("[TB] FAIL exc_over_correct_sel: got %0d expected 5", obs_sel); end
        fetch_ready = 0; exc_valid = 1; exc_target = 32'hBFC0_0380;
        applyStimulus();
        exc_valid = 0; mispred_valid = 1; mispred_target = 32'h2222_0000;
        applyStimulus();
        checks++; if (obs_sel !== 3'd7) begin failures++; $display("[TB] FAIL low_in_hold_sel: got %0d expected 7", obs_sel); end
        mispred_valid = 0; fetch_ready = 1;
        applyStimulus();
        checks++; if (pc !== 32'hBFC0_0380) begin failures++; $display("[TB] FAIL correct_under_exc_pc: got %h expected bfc00380", pc); end
        checks++; if (obs_sel !== 3'd5) begin failures++; $display("[TB] FAIL correct_under_exc_sel: got %0d expected 5", obs_sel); end
        fetch_ready = 0; mispred_valid = 1; mispred_target = 32'h3333_0000;
        applyStimulus();
        mispred_target = 32'h4444_0000;
        applyStimulus();
        mispred_valid = 0; fetch_ready = 1;
        applyStimulus();
        checks++; if (pc !== 32'h4444_0000) begin failures++; $display("[TB] FAIL equal_prio_overwrite_pc: got %h expected 44440000", pc); end
    endtask

    task automatic test_same_cycle();
        fetch_ready = 1;
        eret_valid = 1; eret_target = 32'h1234_0000;
        refetch_valid = 1; refetch_target = 32'h5678_0000;
        bpu_valid = 1; bpu_target = 32'h9ABC_0000;
        applyStimulus();
        clear_requests();
        checks++; if (pc !== 32'h1234_0000) begin failures++; $display("[TB] FAIL same_cycle_pc: got %h expected 12340000", pc); end
        checks++; if (obs_sel !== 3'd3) begin failures++; $display("[TB] FAIL same_cycle_sel: got %0d expected 3", obs_sel); end
        checks++; if (redirect_flush !== 1'b1) begin failures++; $display("[TB] FAIL same_cycle_flush: got %b expected 1", redirect_flush); end
    endtask

    task automatic test_wrap();
        fetch_ready = 1; mispred_valid = 1; mispred_target = 32'hFFFF_FFFC;
        applyStimulus();
        mispred_valid = 0;
        applyStimulus();
        checks++; if (pc !== 32'h0000_0000) begin failures++; $display("[TB] FAIL wrap_pc: got %h expected 00000000", pc); end
        checks++; if (obs_sel !== 3'd0) begin failures++; $display("[TB] FAIL wrap_sel: got %0d expected 0", obs_sel); end
    endtask

    task automatic test_reset_in_hold();
        fetch_ready = 0; refetch_valid = 1; refetch_target = 32'h3333_0000;
        applyStimulus();
        refetch_valid = 0;
        checks++; if (redirect_pending !== 1'b1) begin failures++; $display("[TB] FAIL hold_before_reset: got %b expected 1", redirect_pending); end
        rst = 1;
        applyStimulus();
        checks++; if (pc !== RESET_PC) begin failures++; $display("[TB] FAIL hold_reset_pc: got %h expected %h", pc, RESET_PC); end
        checks++; if (redirect_pending !== 1'b0) begin failures++; $display("[TB] FAIL hold_reset_pending: got %b expected 0", redirect_pending); end
        rst = 0; fetch_ready = 1;
        applyStimulus();
        checks++; if (pc !== 32'hBFC0_0004) begin failures++; $display("[TB] FAIL discarded_pending_pc: got %h expected bfc00004", pc); end
        checks++; if (redirect_flush !== 1'b0) begin failures++; $display("[TB] FAIL discarded_pending_flush: got %b expected 0", redirect_flush); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(99) == 0);
            fetch_ready    = ($urandom_range(9) < 6);
            exc_valid      = ($urandom_range(15) == 0);
            eret_valid     = ($urandom_range(15) == 0);
            refetch_valid  = ($urandom_range(11) == 0);
            mispred_valid  = ($urandom_range(7) == 0);
            bpu_valid      = ($urandom_range(3) == 0);
            exc_target     = $urandom;
            eret_target    = $urandom;
            refetch_target = $urandom;
            mispred_target = $urandom;
            bpu_target     = $urandom;
            applyStimulus();
            checks++; if (pc !== m_pc) begin failures++; $display("[TB] FAIL rand_pc[%0d]: got %h expected %h", n, pc, m_pc); end
            checks++; if (redirect_flush !== m_flush) begin failures++; $display("[TB] FAIL rand_flush[%0d]: got %b expected %b", n, redirect_flush, m_flush); end
            checks++; if (redirect_pending !== m_pend) begin failures++; $display("[TB] FAIL rand_pending[%0d]: got %b expected %b", n, redirect_pending, m_pend); end
            if (!rst) begin
                checks++; if (obs_sel !== 3'(exp_sel)) begin failures++; $display("[TB] FAIL rand_sel[%0d]: got %0d expected %0d", n, obs_sel, exp_sel); end
            end
        end
        rst = 0; clear_requests();
    endtask

    initial begin
        checks = 0; failures = 0;
        m_pc = RESET_PC; m_pend = 0; m_pend_prio = 0; m_pend_code = 0; m_pend_tgt = '0; m_flush = 0;
        exp_sel = 0; obs_sel = '0;
        rst = 1; fetch_ready = 0; clear_requests();
        exc_target = '0; eret_target = '0; refetch_target = '0; mispred_target = '0; bpu_target = '0;
        test_reset();
        test_bpu();
        test_stall_buffer();
        test_priority_hold();
        test_same_cycle();
        test_wrap();
        test_reset_in_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
